// File: rtl/fisc_fetch_unit.sv
// FISC instruction fetch: reads memory words, unpacks them lane by lane and queues instructions for decode.
// Define FISC_FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module fisc_fetch_unit #(
    parameter int WORD_W     = 64,
    parameter int INSN_W     = 32,
    parameter int ADDR_W     = 11,
    parameter int PC_W       = 64,
    parameter int FIFO_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wait_n,
    input  logic                          redirect_valid,
    input  logic [PC_W-1:0]               redirect_pc,
    output logic                          mem_rd,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [WORD_W-1:0]             mem_rdata,
    input  logic                          mem_rvalid,
    output logic                          insn_valid,
    output logic [INSN_W-1:0]             insn,
    output logic [PC_W-1:0]               insn_pc,
    input  logic                          insn_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FISC_FETCH_PERF_EN
    ,
    output logic [31:0]                   perf_fetched,
    output logic [31:0]                   perf_stall
`endif
);

    localparam int LANES  = WORD_W / INSN_W;
    localparam int IB     = INSN_W / 8;
    localparam int WB     = WORD_W / 8;
    localparam int IB_L   = $clog2(IB);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    localparam logic [PC_W-1:0] PC_STEP   = PC_W'(IB);
    localparam logic [PC_W-1:0] PC_ALIGN  = ~(PC_W'(IB - 1));
    localparam logic [PC_W-1:0] WB_DIV    = PC_W'(WB);
    localparam logic [PC_W-1:0] LANES_DIV = PC_W'(LANES);

    localparam logic [1:0] ST_REQ    = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_UNPACK = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              drop_q, drop_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [WORD_W-1:0] word_q;

    logic [INSN_W-1:0] fifo_insn_q [FIFO_DEPTH];
    logic [PC_W-1:0]   fifo_pc_q   [FIFO_DEPTH];

    logic              pop, push, full, capture;
    logic [INSN_W-1:0] push_insn;
    logic [LANE_W-1:0] lane_start;

    assign insn_valid = (level_q != '0);
    assign insn       = insn_valid ? fifo_insn_q[rd_ptr_q] : '0;
    assign insn_pc    = insn_valid ? fifo_pc_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;

    always_comb begin
        pop     = insn_valid && insn_ready && !redirect_valid;
        full    = (level_q == LVL_W'(FIFO_DEPTH));
        push    = (state_q == ST_UNPACK) && wait_n && !redirect_valid && (!full || pop);
        capture = (state_q == ST_WAIT) && mem_rvalid && !redirect_valid;

        push_insn = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_q == LANE_W'(l)) push_insn = word_q[l*INSN_W +: INSN_W];
        end
        // A word may be entered mid-way after a redirect, so the first lane comes from the PC.
        lane_start = LANE_W'((pc_q >> IB_L) % LANES_DIV);

        state_d    = state_q;
        pc_d       = pc_q;
        lane_d     = lane_q;
        drop_d     = drop_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;

        if (redirect_valid) begin
            pc_d    = redirect_pc & PC_ALIGN;
            state_d = ST_REQ;
            // The read in flight belongs to the old path; swallow its response before re-issuing.
            if (state_q == ST_WAIT) drop_d = !mem_rvalid;
            else if (drop_q && mem_rvalid) drop_d = 1'b0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (drop_q) begin
                        if (mem_rvalid) drop_d = 1'b0;
                    end else if (wait_n && !full) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = ADDR_W'(pc_q / WB_DIV);
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (capture) begin
                        lane_d  = lane_start;
                        state_d = ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    if (push) begin
                        pc_d   = pc_q + PC_STEP;
                        lane_d = lane_q + LANE_W'(1);
                        if (lane_q == LANE_W'(LANES - 1)) state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      level_d = level_q + LVL_W'(1);
            else if (pop && !push) level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            lane_q     <= '0;
            drop_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            lane_q     <= lane_d;
            drop_q     <= drop_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Data storage carries no reset; outputs are masked by insn_valid instead.
    always_ff @(posedge clk) begin
        if (capture) word_q <= mem_rdata;
        if (push) begin
            fifo_insn_q[wr_ptr_q] <= push_insn;
            fifo_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

`ifdef FISC_FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;
    logic        stall;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    assign stall = (state_q == ST_UNPACK) && full && !pop && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push)  perf_fetched_q <= sat_inc(perf_fetched_q);
            if (stall) perf_stall_q   <= sat_inc(perf_stall_q);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fisc_fetch_unit.sv
// Directed bench for fisc_fetch_unit: a 64-bit-word instance (A) and a 128-bit-word instance (B).
module tb_fisc_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, wait_n, redirect_valid, mem_rvalid, insn_ready;
    logic [63:0] redirect_pc, mem_rdata, insn_pc;
    logic        mem_rd, insn_valid;
    logic [10:0] mem_addr;
    logic [31:0] insn;
    logic [2:0]  fifo_level;

    logic         b_wait_n, b_redirect_valid, b_mem_rvalid, b_insn_ready;
    logic [63:0]  b_redirect_pc, b_insn_pc;
    logic [127:0] b_mem_rdata;
    logic         b_mem_rd, b_insn_valid;
    logic [10:0]  b_mem_addr;
    logic [31:0]  b_insn;
    logic [2:0]   b_fifo_level;

`ifdef FISC_FETCH_PERF_EN
    logic [31:0] a_pf, a_ps, b_pf, b_ps;
`endif

    fisc_fetch_unit u_a (
        .clk(clk), .reset_n(reset_n), .wait_n(wait_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc), .insn_ready(insn_ready),
        .fifo_level(fifo_level)
`ifdef FISC_FETCH_PERF_EN
        , .perf_fetched(a_pf), .perf_stall(a_ps)
`endif
    );

    fisc_fetch_unit #(.WORD_W(128)) u_b (
        .clk(clk), .reset_n(reset_n), .wait_n(b_wait_n),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata), .mem_rvalid(b_mem_rvalid),
        .insn_valid(b_insn_valid), .insn(b_insn), .insn_pc(b_insn_pc), .insn_ready(b_insn_ready),
        .fifo_level(b_fifo_level)
`ifdef FISC_FETCH_PERF_EN
        , .perf_fetched(b_pf), .perf_stall(b_ps)
`endif
    );

    typedef struct packed {
        logic        w;
        logic        rdy;
        logic        rd;
        logic [10:0] addr;
        logic        v;
        logic [31:0] insn;
        logic [63:0] pc;
        logic [2:0]  lvl;
    } vec_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
    } ent_t;

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] due;
    } req_t;

    vec_t        vecs [9];
    ent_t        popq[$], b_popq[$];
    req_t        a_pend[$], b_pend[$];
    logic [10:0] b_addrs[$];
    int          n_checks = 0, n_pass = 0;
    logic [31:0] cyc = 0;
    int          a_lat = 1;
    logic        a_inject = 1'b0;
    logic [63:0] exp_pc;
    int          viol, rd_cnt, k;
    logic [10:0] last_addr;

    function automatic logic [31:0] ins_at(input logic [63:0] p);
        return 32'h5A00_0000 + 32'(p >> 2);
    endfunction

    function automatic logic [31:0] model_a(input logic [63:0] p);
        if (p < 64'd8) return p[2] ? 32'hBBBB_BBBB : 32'hAAAA_AAAA;
        return ins_at(p);
    endfunction

    function automatic logic [63:0] word_a(input logic [10:0] a);
        if (a == 11'd0) return 64'hBBBB_BBBB_AAAA_AAAA;
        return {ins_at(64'(a) * 8 + 4), ins_at(64'(a) * 8)};
    endfunction

    function automatic logic [127:0] word_b(input logic [10:0] a);
        return {ins_at(64'(a) * 16 + 12), ins_at(64'(a) * 16 + 8),
                ins_at(64'(a) * 16 + 4), ins_at(64'(a) * 16)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // One clock: log pops decided this cycle, advance, then let the memory models respond.
    task automatic tick();
        req_t r;
        if (reset_n && insn_valid && insn_ready && !redirect_valid)
            popq.push_back({insn_pc, insn});
        if (reset_n && b_insn_valid && b_insn_ready && !b_redirect_valid)
            b_popq.push_back({b_insn_pc, b_insn});
        @(posedge clk);
        #1;
        cyc++;
        mem_rvalid = 1'b0;
        if (a_pend.size() > 0 && a_pend[0].due == cyc) begin
            r = a_pend.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = word_a(r.addr);
        end else if (a_inject) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        a_inject = 1'b0;
        if (mem_rd) a_pend.push_back({mem_addr, cyc + 32'(a_lat)});
        b_mem_rvalid = 1'b0;
        if (b_pend.size() > 0 && b_pend[0].due == cyc) begin
            r = b_pend.pop_front();
            b_mem_rvalid = 1'b1;
            b_mem_rdata  = word_b(r.addr);
        end
        if (b_mem_rd) b_pend.push_back({b_mem_addr, cyc + 32'd1});
    endtask

    task automatic verify_a();
        ent_t e;
        while (popq.size() > 0) begin
            e = popq.pop_front();
            check($sformatf("a_stream_pc_%0h", exp_pc), e.pc, exp_pc);
            check($sformatf("a_stream_insn_%0h", e.pc), 64'(e.insn), 64'(model_a(e.pc)));
            exp_pc += 64'd4;
        end
    endtask

    initial begin
        ent_t e;
        logic [63:0] b_exp;

        reset_n = 1'b0; wait_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        insn_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        b_wait_n = 1'b1; b_redirect_valid = 1'b0; b_redirect_pc = '0;
        b_insn_ready = 1'b0; b_mem_rvalid = 1'b0; b_mem_rdata = '0;

        //          w     rdy   rd    addr   v     insn          pc      lvl
        vecs[0] = '{1'b1, 1'b1, 1'b1, 11'd0, 1'b0, 32'h0,        64'h0, 3'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 11'd0, 1'b0, 32'h0,        64'h0, 3'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 11'd0, 1'b0, 32'h0,        64'h0, 3'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 11'd0, 1'b1, 32'hAAAAAAAA, 64'h0, 3'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 11'd0, 1'b1, 32'hBBBBBBBB, 64'h4, 3'd1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 11'd1, 1'b0, 32'h0,        64'h0, 3'd0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 11'd1, 1'b0, 32'h0,        64'h0, 3'd0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 11'd1, 1'b0, 32'h0,        64'h0, 3'd0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 11'd1, 1'b1, 32'h5A000002, 64'h8, 3'd1};

        repeat (3) tick();
        check("rst_mem_rd", 64'(mem_rd), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);
        check("rst_insn_valid", 64'(insn_valid), 0);
        check("rst_insn", 64'(insn), 0);
        check("rst_insn_pc", insn_pc, 0);
        check("rst_level", 64'(fifo_level), 0);

        reset_n = 1'b1;
        exp_pc  = 64'h0;
        for (int i = 0; i < 9; i++) begin
            wait_n     = vecs[i].w;
            insn_ready = vecs[i].rdy;
            tick();
            check($sformatf("row%0d_mem_rd", i), 64'(mem_rd), 64'(vecs[i].rd));
            check($sformatf("row%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].addr));
            check($sformatf("row%0d_valid", i), 64'(insn_valid), 64'(vecs[i].v));
            check($sformatf("row%0d_insn", i), 64'(insn), 64'(vecs[i].insn));
            check($sformatf("row%0d_pc", i), insn_pc, vecs[i].pc);
            check($sformatf("row%0d_level", i), 64'(fifo_level), 64'(vecs[i].lvl));
        end

        // Back-pressure: queue fills, fetching stops, one pop lets exactly one word in.
        insn_ready = 1'b0;
        viol = 0;
        repeat (20) begin
            tick();
            if (mem_rd && fifo_level == 3'd4) viol++;
        end
        check("full_rd_while_full", 64'(viol), 0);
        check("full_level", 64'(fifo_level), 4);
        check("full_head_pc", insn_pc, 64'h8);
        insn_ready = 1'b1;
        tick();
        insn_ready = 1'b0;
        check("one_pop_level", 64'(fifo_level), 3);
        rd_cnt = 0;
        last_addr = '0;
        repeat (12) begin
            tick();
            if (mem_rd) begin
                rd_cnt++;
                last_addr = mem_addr;
            end
        end
        check("resume_rd_count", 64'(rd_cnt), 1);
        check("resume_rd_addr", 64'(last_addr), 3);
        check("refill_level", 64'(fifo_level), 4);
        check("refill_head_pc", insn_pc, 64'hC);

        // Redirect while a slow read is outstanding.
        a_lat = 3;
        insn_ready = 1'b1;
        k = 0;
        while (!mem_rd && k < 60) begin tick(); k++; end
        check("wait_req_seen", 64'(mem_rd), 1);
        verify_a();
        redirect_valid = 1'b1;
        redirect_pc = 64'h2C;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 64'h2C;
        check("redir_wait_level", 64'(fifo_level), 0);
        check("redir_wait_valid", 64'(insn_valid), 0);
        k = 0;
        while (!mem_rd && k < 60) begin tick(); k++; end
        check("redir_rd_seen", 64'(mem_rd), 1);
        check("redir_addr", 64'(mem_addr), 5);
        k = 0;
        while (!insn_valid && k < 60) begin tick(); k++; end
        check("redir_first_pc", insn_pc, 64'h2C);
        check("redir_first_insn", 64'(insn), 64'h5A00000B);
        a_lat = 1;

        // Redirect coinciding with a pop at level 3.
        insn_ready = 1'b0;
        k = 0;
        while (fifo_level != 3'd3 && k < 60) begin tick(); k++; end
        check("lvl3_reached", 64'(fifo_level), 3);
        verify_a();
        insn_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 64'h100;
        check("redir_pop_level", 64'(fifo_level), 0);
        check("redir_pop_valid", 64'(insn_valid), 0);

        // Pause mid-word for 10 cycles, with a stray rvalid thrown in.
        k = 0;
        while (!(insn_valid && insn_pc == 64'h100) && k < 60) begin tick(); k++; end
        check("pc100_seen", insn_pc, 64'h100);
        wait_n = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) a_inject = 1'b1;
            tick();
            if (mem_rd) rd_cnt++;
        end
        check("hold_no_rd", 64'(rd_cnt), 0);
        check("hold_level", 64'(fifo_level), 0);
        wait_n = 1'b1;
        tick();
        check("resume_valid", 64'(insn_valid), 1);
        check("resume_pc", insn_pc, 64'h104);
        check("resume_insn", 64'(insn), 64'(model_a(64'h104)));
        repeat (20) tick();
        verify_a();

        // 4-lane instance: redirect to an unaligned PC in the last lane.
        check("b_full_level", 64'(b_fifo_level), 4);
        check("b_head_pc", b_insn_pc, 64'h0);
        check("b_head_insn", 64'(b_insn), 64'(ins_at(64'h0)));
        b_insn_ready = 1'b1;
        b_redirect_valid = 1'b1;
        b_redirect_pc = 64'h1F;
        tick();
        b_redirect_valid = 1'b0;
        check("b_redir_level", 64'(b_fifo_level), 0);
        k = 0;
        while ((b_addrs.size() < 2 || b_popq.size() < 5) && k < 60) begin
            tick();
            if (b_mem_rd) b_addrs.push_back(b_mem_addr);
            k++;
        end
        check("b_req_count", 64'(b_addrs.size() >= 2), 1);
        check("b_req0_addr", 64'(b_addrs.size() > 0 ? b_addrs[0] : 11'h7FF), 1);
        check("b_req1_addr", 64'(b_addrs.size() > 1 ? b_addrs[1] : 11'h7FF), 2);
        check("b_pop_count", 64'(b_popq.size() >= 5), 1);
        b_exp = 64'h1C;
        for (int i = 0; i < 5 && b_popq.size() > 0; i++) begin
            e = b_popq.pop_front();
            check($sformatf("b_stream_pc_%0d", i), e.pc, b_exp);
            check($sformatf("b_stream_insn_%0d", i), 64'(e.insn), 64'(ins_at(b_exp)));
            b_exp += 64'd4;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
